led_scan: RTL
=============

LED_SCAN -- requirements
Module: led_scan

Interface
REQ-001 Parameter DIV, default 1000: clock cycles each row is driven (ON period); legal range 1..65535.
REQ-002 Parameter BLANK, default 16: all-off clock cycles between rows (anti-ghosting); legal range 1..65535.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  scan enable; 0 = display dark, FSM parked.
REQ-006 led_reg  input  128  register-file image; word k = bits [16k+15:16k], k=0..7 (r0..r7).
REQ-007 led_misc  input  128  datapath image; word k = bits [16k+15:16k] (pc, ir, sr1, sr2, alu, dr, 0, 0).
REQ-008 led_ph  input  4  current phase, one-hot.
REQ-009 led_row  output  16  row drive, active-high; one-hot or all-zero.
REQ-010 led_col  output  16  column data for the driven row, active-high.
REQ-011 led_phase  output  4  registered copy of led_ph.
REQ-012 frame_start  output  1  single-cycle pulse marking the start of each frame.

Function
REQ-013 Row map: rows 0..7 show led_reg words 0..7; rows 8..15 show led_misc words 0..7; led_col[j] = bit j of that word.
REQ-014 FSM states: BLANK and ON; a 16-bit cycle counter and a 4-bit row index.
REQ-015 BLANK lasts exactly BLANK cycles with led_row=0 and led_col=0, then goes to ON for the current row.
REQ-016 ON lasts exactly DIV cycles with led_row = one-hot(row index) and led_col = snapshot word; then the row index increments and the FSM goes to BLANK.
REQ-017 Row index wraps 15 -> 0; frame period = 16*(DIV+BLANK) cycles.
REQ-018 All 256 input bits are captured into a snapshot on the edge that moves the FSM from BLANK into ON for row 0; rows 0..15 of that frame show only this snapshot (no tearing).
REQ-019 Input changes after the row-0 snapshot edge appear no earlier than the next frame.
REQ-020 frame_start is 1 during exactly the first ON cycle of row 0 and 0 otherwise.
REQ-021 led_row is never non-zero in the same cycle as a row transition; at least BLANK all-off cycles separate any two different one-hot values.
REQ-022 led_phase = led_ph delayed by one cycle, updated every cycle regardless of en or FSM state.
REQ-023 en=0, sampled at any edge including mid-ON: on that edge led_row, led_col and frame_start go to 0, the FSM goes to BLANK, the counter clears, and the row index goes to 0.
REQ-024 en held 0: the FSM stays parked; after en returns to 1, the sequence restarts exactly as after reset (BLANK, then a fresh snapshot and row 0).
REQ-025 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-026 RST=1 asynchronously forces: state BLANK, counter 0, row index 0, snapshot 0, led_row=0, led_col=0, led_phase=0, frame_start=0.
REQ-027 RST asserted mid-frame aborts the frame immediately; no partial row output survives reset.
REQ-028 After RST deasserts with en=1, led_row first becomes 16'h0001 at the BLANK-th rising edge.

Verification (DIV=4, BLANK=2)
REQ-029 Reset release, en=1, led_reg word0=16'hA5A5 -> edges 1-2 dark; cycles 3-6 led_row=16'h0001, led_col=16'hA5A5, frame_start=1 only in cycle 3; cycles 7-8 dark; cycle 9 led_row=16'h0002.
REQ-030 Full frame with led_misc word0 (pc)=16'h0123 -> row 8 shows led_col=16'h0123; row 15 shows 16'h0000; next frame_start 96 cycles after the previous one.
REQ-031 Change led_reg word3 from 16'h00FF to 16'hFF00 during row 1 -> row 3 of this frame shows 16'h00FF; row 3 of the next frame shows 16'hFF00.
REQ-032 Drop en in the 2nd ON cycle of row 5, hold 3 cycles, restore -> outputs 0 on the next edge, frame_start absent while parked; after restore, 2 dark cycles, then row 0 with frame_start=1.
REQ-033 Assert RST asynchronously mid-ON of row 10 -> led_row, led_col and led_phase are 0 before the next clock edge; post-release timing matches REQ-029.
REQ-034 Walk led_ph through 0001, 0010, 0100, 1000 on consecutive cycles -> led_phase follows with exactly one cycle of lag, independent of en.

Source files
------------

// File: rtl/led_scan.sv
// 16-row LED matrix scanner: blank/on row sequencing with a per-frame
// snapshot of the register-file and datapath images.
module led_scan #(
   parameter int DIV   = 1000,
   parameter int BLANK = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         en,
   input  logic [127:0] led_reg,
   input  logic [127:0] led_misc,
   input  logic [3:0]   led_ph,
   output logic [15:0]  led_row,
   output logic [15:0]  led_col,
   output logic [3:0]   led_phase,
   output logic         frame_start
);

   localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
   localparam logic [15:0] BLANK_M1 = 16'(BLANK - 1);

   typedef enum logic {
      ST_BLANK,
      ST_ON
   } state_t;

   state_t         state, state_n;
   logic [15:0]    cnt, cnt_n;
   logic [3:0]     row, row_n;
   logic [255:0]   snap, snap_n;
   logic           cap;
   logic [15:0]    word;
   logic [15:0]    row_out_n;
   logic [15:0]    col_out_n;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= ST_BLANK;
         cnt         <= '0;
         row         <= '0;
         snap        <= '0;
         led_row     <= '0;
         led_col     <= '0;
         led_phase   <= '0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         row         <= row_n;
         snap        <= snap_n;
         led_row     <= row_out_n;
         led_col     <= col_out_n;
         led_phase   <= led_ph;
         frame_start <= cap;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      row_n   = row;
      cap     = 1'b0;
      if (!en) begin
         state_n = ST_BLANK;
         cnt_n   = '0;
         row_n   = '0;
      end else begin
         unique case (state)
            ST_BLANK: begin
               if (cnt == BLANK_M1) begin
                  state_n = ST_ON;
                  cnt_n   = '0;
                  cap     = (row == 4'd0);
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
            ST_ON: begin
               if (cnt == DIV_M1) begin
                  state_n = ST_BLANK;
                  cnt_n   = '0;
                  row_n   = row + 4'd1;
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
            default: state_n = ST_BLANK;
         endcase
      end
   end

   // Row 0 of a frame must already show the freshly captured image.
   always_comb begin
      snap_n    = cap ? {led_misc, led_reg} : snap;
      word      = snap_n[{row_n, 4'd0} +: 16];
      row_out_n = '0;
      col_out_n = '0;
      if (state_n == ST_ON) begin
         row_out_n = 16'h0001 << row_n;
         col_out_n = word;
      end
   end

endmodule
